// File: rtl/matrix_input_ctrl.sv
// Parses UART ASCII bytes into dims / ID / matrix-element events and writes elements to memory.
// Optional INPUT_ZERO_FILL_EN: an LF inside the element list zero-fills the rest of the matrix.
module matrix_input_ctrl #(
    parameter int          MAX_DIM   = 5,
    parameter int          MAX_ELEM  = 9,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        is_gen_mode,
    input  logic [1:0]  task_mode,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        addr_ready,
    input  logic [7:0]  base_addr,
    output logic        dims_valid,
    output logic [31:0] dim_m,
    output logic [31:0] dim_n,
    output logic        id_valid,
    output logic [31:0] id_val,
    output logic        rx_done,
    output logic        error_flag,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [3:0]  fsm_state
);

    // Handshake: dims_valid rises on entry to DIMS and stays high until addr_ready
    // is sampled high (store task) or for exactly one cycle (dims-only task).
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_M    = 4'd1,
        GET_N    = 4'd2,
        DIMS     = 4'd3,
        GET_ELEM = 4'd4,
        GEN_ELEM = 4'd5,
        FILL     = 4'd6,
        DONE     = 4'd7,
        GET_ID   = 4'd8,
        ERR      = 4'd9
    } state_t;

    localparam logic [8:0] DIM_MAX_V  = 9'(MAX_DIM);
    localparam logic [8:0] ELEM_MAX_V = 9'(MAX_ELEM);
    localparam logic [7:0] ELEM_MOD   = 8'(MAX_ELEM + 1);

    state_t      state, state_n;
    logic        en_prev;
    logic [1:0]  mode_r, mode_n;
    logic        gen_r, gen_n;
    logic [8:0]  acc, acc_n;
    logic        have_digit, have_n;
    logic [7:0]  m_r, m_n;
    logic [7:0]  total, total_n;
    logic [7:0]  idx, idx_n;
    logic [7:0]  base, base_n;
    logic [7:0]  lfsr;

    logic        dims_valid_n, id_valid_n, rx_done_n, error_n, we_n;
    logic [7:0]  dim_m_r, dim_n_r, dim_m_n, dim_n_n;
    logic [7:0]  id_val_r, id_val_n;
    logic [7:0]  addr_n, wdata_n;

    logic        en_rise;
    logic        is_digit, is_sep, is_lf;
    logic        tok_digit, tok_bad, tok_close, tok_ovf;
    logic [12:0] acc_wide;
    logic [7:0]  tok_val, lfsr_mod, last_idx;
    logic        dim_ok, elem_ok;

    assign en_rise   = en & ~en_prev;
    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_sep    = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign is_lf     = rx_valid && (rx_data == 8'h0A);
    assign tok_digit = rx_valid && is_digit;
    assign tok_bad   = rx_valid && !is_digit && !is_sep;
    assign tok_close = rx_valid && is_sep && have_digit;
    assign acc_wide  = 13'(acc) * 13'd10 + 13'(rx_data[3:0]);
    assign tok_ovf   = tok_digit && (acc_wide > 13'd255);
    assign tok_val   = acc[7:0];
    assign dim_ok    = (acc >= 9'd1) && (acc <= DIM_MAX_V);
    assign elem_ok   = (acc <= ELEM_MAX_V);
    assign lfsr_mod  = lfsr % ELEM_MOD;
    assign last_idx  = total - 8'd1;

    assign dim_m     = {24'd0, dim_m_r};
    assign dim_n     = {24'd0, dim_n_r};
    assign id_val    = {24'd0, id_val_r};
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        mode_n     = mode_r;
        gen_n      = gen_r;
        acc_n      = acc;
        have_n     = have_digit;
        m_n        = m_r;
        total_n    = total;
        idx_n      = idx;
        base_n     = base;
        dim_m_n    = dim_m_r;
        dim_n_n    = dim_n_r;
        id_val_n   = id_val_r;
        id_valid_n = 1'b0;
        rx_done_n  = 1'b0;
        we_n       = 1'b0;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;

        // Dropping en aborts everything, including a byte arriving on the same cycle.
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en_rise) begin
                        mode_n = task_mode;
                        gen_n  = is_gen_mode;
                        acc_n  = 9'd0;
                        have_n = 1'b0;
                        case (task_mode)
                            2'd0, 2'd1: state_n = GET_M;
                            2'd2:       state_n = GET_ID;
                            default:    state_n = ERR;
                        endcase
                    end
                end
                GET_M, GET_N, GET_ELEM, GET_ID: begin
                    if (tok_bad || tok_ovf) begin
                        state_n = ERR;
                    end else if (tok_digit) begin
                        acc_n  = acc_wide[8:0];
                        have_n = 1'b1;
                    end else if (tok_close) begin
                        acc_n  = 9'd0;
                        have_n = 1'b0;
                        case (state)
                            GET_M: begin
                                if (dim_ok) begin
                                    m_n     = tok_val;
                                    state_n = GET_N;
                                end else begin
                                    state_n = ERR;
                                end
                            end
                            GET_N: begin
                                if (dim_ok) begin
                                    dim_m_n = m_r;
                                    dim_n_n = tok_val;
                                    total_n = 8'(m_r * tok_val);
                                    state_n = DIMS;
                                end else begin
                                    state_n = ERR;
                                end
                            end
                            GET_ELEM: begin
                                if (elem_ok) begin
                                    we_n    = 1'b1;
                                    addr_n  = base + idx;
                                    wdata_n = tok_val;
                                    idx_n   = idx + 8'd1;
                                    if (idx == last_idx) begin
                                        state_n = DONE;
                                    end
`ifdef INPUT_ZERO_FILL_EN
                                    else if (is_lf) begin
                                        state_n = FILL;
                                    end
`endif
                                end else begin
                                    state_n = ERR;
                                end
                            end
                            default: begin
                                id_valid_n = 1'b1;
                                id_val_n   = tok_val;
                                state_n    = IDLE;
                            end
                        endcase
                    end
`ifdef INPUT_ZERO_FILL_EN
                    else if (is_lf && (state == GET_ELEM)) begin
                        state_n = FILL;
                    end
`endif
                end
                DIMS: begin
                    if (mode_r == 2'd1) begin
                        state_n = IDLE;
                    end else if (addr_ready) begin
                        base_n  = base_addr;
                        idx_n   = 8'd0;
                        state_n = gen_r ? GEN_ELEM : GET_ELEM;
                    end
                end
                GEN_ELEM, FILL: begin
                    we_n    = 1'b1;
                    addr_n  = base + idx;
                    wdata_n = (state == GEN_ELEM) ? lfsr_mod : 8'd0;
                    idx_n   = idx + 8'd1;
                    if (idx == last_idx) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    rx_done_n = 1'b1;
                    state_n   = IDLE;
                end
                default: begin
                    state_n = ERR;
                end
            endcase
        end

        dims_valid_n = (state_n == DIMS);
        error_n      = (state_n == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev    <= 1'b0;
            mode_r     <= 2'd0;
            gen_r      <= 1'b0;
            acc        <= 9'd0;
            have_digit <= 1'b0;
            m_r        <= 8'd0;
            total      <= 8'd0;
            idx        <= 8'd0;
            base       <= 8'd0;
            dims_valid <= 1'b0;
            dim_m_r    <= 8'd0;
            dim_n_r    <= 8'd0;
            id_valid   <= 1'b0;
            id_val_r   <= 8'd0;
            rx_done    <= 1'b0;
            error_flag <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'd0;
            mem_wdata  <= 8'd0;
        end else begin
            en_prev    <= en;
            mode_r     <= mode_n;
            gen_r      <= gen_n;
            acc        <= acc_n;
            have_digit <= have_n;
            m_r        <= m_n;
            total      <= total_n;
            idx        <= idx_n;
            base       <= base_n;
            dims_valid <= dims_valid_n;
            dim_m_r    <= dim_m_n;
            dim_n_r    <= dim_n_n;
            id_valid   <= id_valid_n;
            id_val_r   <= id_val_n;
            rx_done    <= rx_done_n;
            error_flag <= error_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
        end
    end

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; a nonzero seed keeps it off the all-zero lockup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule

// File: tb/tb_matrix_input_ctrl.sv
// Directed bench for matrix_input_ctrl: store/dims/ID tasks, generate mode, errors, abort, zero fill.
module tb_matrix_input_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        is_gen_mode;
    logic [1:0]  task_mode;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        addr_ready;
    logic [7:0]  base_addr;
    logic        dims_valid;
    logic [31:0] dim_m;
    logic [31:0] dim_n;
    logic        id_valid;
    logic [31:0] id_val;
    logic        rx_done;
    logic        error_flag;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [3:0]  fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    matrix_input_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .is_gen_mode(is_gen_mode),
        .task_mode(task_mode), .rx_data(rx_data), .rx_valid(rx_valid),
        .addr_ready(addr_ready), .base_addr(base_addr), .dims_valid(dims_valid),
        .dim_m(dim_m), .dim_n(dim_n), .id_valid(id_valid), .id_val(id_val),
        .rx_done(rx_done), .error_flag(error_flag), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference LFSR and event log ----------------
    logic [7:0] ref_lfsr, ref_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_lfsr <= 8'hA5;
            ref_prev <= 8'hA5;
        end else begin
            ref_prev <= ref_lfsr;
            ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] exp_q[$];
    int         wr_cyc_q[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         dv_cnt = 0;
    int         id_cnt = 0;
    logic [31:0] id_last = 32'd0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            exp_q.push_back(8'(ref_prev % 8'd10));
            wr_cyc_q.push_back(cyc);
        end
        if (rx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (dims_valid) dv_cnt = dv_cnt + 1;
        if (id_valid) begin
            id_cnt  = id_cnt + 1;
            id_last = id_val;
        end
    end

    // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_task(input logic [1:0] mode, input logic gen);
        en = 1'b0;
        step(1);
        task_mode   = mode;
        is_gen_mode = gen;
        en          = 1'b1;
        step(1);
    endtask

    task automatic end_task();
        en = 1'b0;
        step(1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            step(1);
            rx_valid = 1'b0;
        end
    endtask

    task automatic grant(input logic [7:0] b);
        base_addr  = b;
        addr_ready = 1'b1;
        step(1);
        addr_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++;
        if ({dims_valid, id_valid, rx_done, error_flag, mem_we} !== 5'b0 ||
            dim_m !== 32'd0 || dim_n !== 32'd0 || id_val !== 32'd0 ||
            mem_addr !== 8'd0 || mem_wdata !== 8'd0 || fsm_state !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_during: got dv=%0b idv=%0b done=%0b err=%0b we=%0b st=%0d want all 0",
                     dims_valid, id_valid, rx_done, error_flag, mem_we, fsm_state);
        end
        rst_n = 1'b1;
        step(2);
        n_cmp++;
        if ({dims_valid, id_valid, rx_done, error_flag, mem_we} !== 5'b0 || fsm_state !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_after: got st=%0d err=%0b want st=0 err=0", fsm_state, error_flag);
        end
    endtask

    task automatic test_store_manual();
        int w0 = wr_addr_q.size();
        int d0 = done_cnt;
        start_task(2'd0, 1'b0);
        send_str("2 3 ");
        n_cmp++;
        if (dims_valid !== 1'b1) begin
            n_bad++; $display("FAIL store_dims_up: got %0b want 1", dims_valid);
        end
        step(3);
        n_cmp++;
        if (dims_valid !== 1'b1 || dim_m !== 32'd2 || dim_n !== 32'd3) begin
            n_bad++; $display("FAIL store_dims_hold: got dv=%0b m=%0d n=%0d want 1 2 3", dims_valid, dim_m, dim_n);
        end
        grant(8'h10);
        n_cmp++;
        if (dims_valid !== 1'b0) begin
            n_bad++; $display("FAIL store_dims_drop: got %0b want 0", dims_valid);
        end
        send_str("1 2 3 4 5 6\n");
        step(4);
        n_cmp++;
        if (wr_addr_q.size() !== w0 + 6) begin
            n_bad++; $display("FAIL store_wr_count: got %0d want 6", wr_addr_q.size() - w0);
        end
        for (int i = 0; i < 6; i++) begin
            if (w0 + i < wr_addr_q.size()) begin
                n_cmp++;
                if (wr_addr_q[w0+i] !== 8'(8'h10 + i) || wr_data_q[w0+i] !== 8'(i + 1)) begin
                    n_bad++;
                    $display("FAIL store_wr%0d: got addr=%h data=%0d want addr=%h data=%0d",
                             i, wr_addr_q[w0+i], wr_data_q[w0+i], 8'(8'h10 + i), i + 1);
                end
            end
        end
        n_cmp++;
        if (done_cnt !== d0 + 1) begin
            n_bad++; $display("FAIL store_done_cnt: got %0d want 1", done_cnt - d0);
        end
        if (wr_cyc_q.size() > 0) begin
            n_cmp++;
            if (done_cyc !== wr_cyc_q[wr_cyc_q.size()-1] + 1) begin
                n_bad++; $display("FAIL store_done_timing: got cyc %0d want %0d", done_cyc, wr_cyc_q[wr_cyc_q.size()-1] + 1);
            end
        end
        end_task();
    endtask

    task automatic test_dims_only();
        int w0 = wr_addr_q.size();
        int d0 = done_cnt;
        int v0 = dv_cnt;
        start_task(2'd1, 1'b0);
        send_str("3  2\r\n");
        step(3);
        n_cmp++;
        if (dim_m !== 32'd3 || dim_n !== 32'd2) begin
            n_bad++; $display("FAIL dims_vals: got m=%0d n=%0d want 3 2", dim_m, dim_n);
        end
        n_cmp++;
        if (dv_cnt - v0 !== 1) begin
            n_bad++; $display("FAIL dims_pulse_len: got %0d cycles want 1", dv_cnt - v0);
        end
        n_cmp++;
        if (wr_addr_q.size() !== w0 || done_cnt !== d0 || fsm_state !== 4'd0) begin
            n_bad++; $display("FAIL dims_side: got wr=%0d done=%0d st=%0d want 0 0 0",
                              wr_addr_q.size() - w0, done_cnt - d0, fsm_state);
        end
        end_task();
    endtask

    task automatic test_read_id(input string s, input logic [31:0] want);
        int i0 = id_cnt;
        start_task(2'd2, 1'b0);
        send_str(s);
        step(2);
        n_cmp++;
        if (id_cnt - i0 !== 1 || id_last !== want) begin
            n_bad++; $display("FAIL id_%0d: got pulses=%0d val=%0d want 1 %0d", want, id_cnt - i0, id_last, want);
        end
        end_task();
    endtask

    task automatic test_generate();
        int w0 = wr_addr_q.size();
        int d0 = done_cnt;
        start_task(2'd0, 1'b1);
        send_str("2 2 ");
        grant(8'h20);
        send_str("5 5 ");
        step(4);
        n_cmp++;
        if (wr_addr_q.size() !== w0 + 4 || done_cnt !== d0 + 1) begin
            n_bad++; $display("FAIL gen_count: got wr=%0d done=%0d want 4 1", wr_addr_q.size() - w0, done_cnt - d0);
        end
        for (int i = 0; i < 4; i++) begin
            if (w0 + i < wr_addr_q.size()) begin
                n_cmp++;
                if (wr_addr_q[w0+i] !== 8'(8'h20 + i) || wr_data_q[w0+i] !== exp_q[w0+i] ||
                    wr_data_q[w0+i] > 8'd9) begin
                    n_bad++;
                    $display("FAIL gen_wr%0d: got addr=%h data=%0d want addr=%h data=%0d",
                             i, wr_addr_q[w0+i], wr_data_q[w0+i], 8'(8'h20 + i), exp_q[w0+i]);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (wr_cyc_q[w0+i] !== wr_cyc_q[w0+i-1] + 1) begin
                        n_bad++; $display("FAIL gen_back_to_back%0d: got gap %0d want 1", i, wr_cyc_q[w0+i] - wr_cyc_q[w0+i-1]);
                    end
                end
            end
        end
        end_task();
    endtask

    task automatic test_error(input string name, input logic [1:0] mode, input string pre,
                              input logic do_grant, input string post);
        int w0;
        int d0 = done_cnt;
        start_task(mode, 1'b0);
        send_str(pre);
        if (do_grant) grant(8'h30);
        send_str(post);
        w0 = wr_addr_q.size();
        send_str("1 1 ");
        step(2);
        n_cmp++;
        if (error_flag !== 1'b1 || fsm_state !== 4'd9) begin
            n_bad++; $display("FAIL err_%s_flag: got err=%0b st=%0d want 1 9", name, error_flag, fsm_state);
        end
        n_cmp++;
        if (wr_addr_q.size() !== w0 || done_cnt !== d0) begin
            n_bad++; $display("FAIL err_%s_quiet: got wr=%0d done=%0d want 0 0", name, wr_addr_q.size() - w0, done_cnt - d0);
        end
        end_task();
        n_cmp++;
        if (error_flag !== 1'b0 || fsm_state !== 4'd0) begin
            n_bad++; $display("FAIL err_%s_clear: got err=%0b st=%0d want 0 0", name, error_flag, fsm_state);
        end
    endtask

    task automatic test_abort();
        int i0 = id_cnt;
        start_task(2'd2, 1'b0);
        send_str("4");
        rx_data  = 8'h20;
        rx_valid = 1'b1;
        en       = 1'b0;
        step(1);
        rx_valid = 1'b0;
        step(3);
        n_cmp++;
        if (id_cnt !== i0 || fsm_state !== 4'd0) begin
            n_bad++; $display("FAIL abort_drop: got id pulses=%0d st=%0d want 0 0", id_cnt - i0, fsm_state);
        end
    endtask

    task automatic test_zero_fill();
        int w0 = wr_addr_q.size();
        int d0 = done_cnt;
        start_task(2'd0, 1'b0);
        send_str("2 2 ");
        grant(8'h40);
        send_str("7\n");
        step(6);
        n_cmp++;
        if (wr_addr_q.size() < w0 + 1 || wr_addr_q[w0] !== 8'h40 || wr_data_q[w0] !== 8'd7) begin
            n_bad++; $display("FAIL fill_first: got %0d writes want first 40<-7", wr_addr_q.size() - w0);
        end
`ifdef INPUT_ZERO_FILL_EN
        n_cmp++;
        if (wr_addr_q.size() !== w0 + 4 || done_cnt !== d0 + 1) begin
            n_bad++; $display("FAIL fill_count: got wr=%0d done=%0d want 4 1", wr_addr_q.size() - w0, done_cnt - d0);
        end
        for (int i = 1; i < 4; i++) begin
            if (w0 + i < wr_addr_q.size()) begin
                n_cmp++;
                if (wr_addr_q[w0+i] !== 8'(8'h40 + i) || wr_data_q[w0+i] !== 8'd0) begin
                    n_bad++; $display("FAIL fill_wr%0d: got addr=%h data=%0d want %h 0", i, wr_addr_q[w0+i], wr_data_q[w0+i], 8'(8'h40 + i));
                end
            end
        end
`else
        n_cmp++;
        if (wr_addr_q.size() !== w0 + 1 || done_cnt !== d0 || fsm_state !== 4'd4) begin
            n_bad++; $display("FAIL nofill_wait: got wr=%0d done=%0d st=%0d want 1 0 4",
                              wr_addr_q.size() - w0, done_cnt - d0, fsm_state);
        end
`endif
        end_task();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        is_gen_mode = 1'b0;
        task_mode   = 2'd0;
        rx_data     = 8'd0;
        rx_valid    = 1'b0;
        addr_ready  = 1'b0;
        base_addr   = 8'd0;
        #3;
        step(2);
        test_reset();
        test_store_manual();
        test_dims_only();
        test_read_id("2 ", 32'd2);
        test_read_id("255\r", 32'd255);
        test_generate();
        test_error("mbig", 2'd0, "", 1'b0, "6 1 ");
        test_error("elem12", 2'd0, "1 1 ", 1'b1, "12 ");
        test_error("badchar", 2'd2, "", 1'b0, "x");
        test_error("idovf", 2'd2, "", 1'b0, "300 ");
        test_error("mode3", 2'd3, "", 1'b0, "");
        test_abort();
        test_zero_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
